// File: rtl/picodevice_pkg.sv
// Shared types and constants for the two-master picorv32 native-port arbiter.
// Holds the FSM encoding, requester indices and the latched request record.
package picodevice_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // addr + wdata + wstrb + instr
  localparam int REQ_W = 69;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } mem_req_t;

  function automatic mem_req_t make_req(input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  wstrb,
                                        input logic        instr);
    mem_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    r.instr = instr;
    return r;
  endfunction

endpackage

// File: rtl/picodevice_rr_pick.sv
// Two-way winner select: m1 burst lock first, then round-robin or fixed m0 priority.
// Owns the tie-break pointer (moves on completion) and the m1 lock counter.
module picodevice_rr_pick
  import picodevice_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int LOCK_MAX    = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_m1_lock,
  input  logic i_last_id,
  input  logic i_grant_en,
  input  logic i_complete,
  input  logic i_complete_id,
  output logic o_win_id
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  logic       r_favour;
  logic [7:0] r_lock_cnt;
  logic       w_lock_hold;

  assign w_lock_hold = (i_last_id == REQ_M1) && i_m1_lock && i_req1 &&
                       (r_lock_cnt < LOCK_MAX_C);

  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of latches.
    o_win_id = REQ_M0;
    if (w_lock_hold) begin
      o_win_id = REQ_M1;
    end else if (i_req0 && i_req1) begin
      if (ROUND_ROBIN != 0) o_win_id = r_favour;
    end else if (i_req1) begin
      o_win_id = REQ_M1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_favour   <= REQ_M0;
      r_lock_cnt <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (i_complete) r_favour <= ~i_complete_id;
      // Count saturates at the limit; any m0 grant or a dropped lock clears it.
      if (!i_m1_lock) begin
        r_lock_cnt <= 8'd0;
      end else if (i_grant_en) begin
        if (o_win_id == REQ_M1)
          r_lock_cnt <= (r_lock_cnt < LOCK_MAX_C) ? r_lock_cnt + 8'd1 : r_lock_cnt;
        else
          r_lock_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/picodevice_mem_arbiter.sv
// Arbitrates picorv32 core (m0) and DMA/debug (m1) onto one native memory port.
// Downstream request fields always come from registers latched at grant time.
module picodevice_mem_arbiter
  import picodevice_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int LOCK_MAX    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant_id,
  output logic        busy
);

  arb_state_e r_state;
  mem_req_t   r_req;
  logic       r_grant_id;

  logic w_busy;
  logic w_grant_en;
  logic w_complete;
  logic w_win_id;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_grant_en = (r_state == ST_IDLE) && (m0_valid || m1_valid);
  assign w_complete = w_busy && s_ready;

  picodevice_rr_pick #(
    .ROUND_ROBIN (ROUND_ROBIN),
    .LOCK_MAX    (LOCK_MAX)
  ) u_pick (
    .clk           (clk),
    .resetn        (resetn),
    .i_req0        (m0_valid),
    .i_req1        (m1_valid),
    .i_m1_lock     (m1_lock),
    .i_last_id     (r_grant_id),
    .i_grant_en    (w_grant_en),
    .i_complete    (w_complete),
    .i_complete_id (r_grant_id),
    .o_win_id      (w_win_id)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      // NOTE: the latched request is ordinary flops, so it is reset like any state.
      r_req      <= '0;
      r_grant_id <= REQ_M0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_state    <= ST_BUSY;
            r_grant_id <= w_win_id;
            r_req      <= (w_win_id == REQ_M1) ?
                          make_req(m1_addr, m1_wdata, m1_wstrb, m1_instr) :
                          make_req(m0_addr, m0_wdata, m0_wstrb, m0_instr);
          end
        end
        ST_BUSY: begin
          // Completes even if the owner has dropped valid meanwhile.
          if (s_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = w_busy;
  assign grant_id = r_grant_id;
  assign s_valid  = w_busy;
  assign s_addr   = r_req.addr;
  assign s_wdata  = r_req.wdata;
  assign s_wstrb  = r_req.wstrb;
  assign s_instr  = r_req.instr;

  assign m0_ready = s_ready && w_busy && (r_grant_id == REQ_M0);
  assign m1_ready = s_ready && w_busy && (r_grant_id == REQ_M1);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: doc/picodevice_mem_arbiter.md
PICODEVICE_MEM_ARBITER -- requirements
Module: picodevice_mem_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternating priority; 0 = fixed priority, m0 wins.
REQ-002 Parameter LOCK_MAX, default 8: maximum consecutive grants m1 may hold under m1_lock (1..255).
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 m0_valid/m0_instr  in  1 each  requester 0 (picorv32 core) request and instruction-fetch flag.
REQ-006 m0_addr/m0_wdata  in  32 each; m0_wstrb  in  4; m0_ready  out  1; m0_rdata  out  32.
REQ-007 m1_valid/m1_instr/m1_lock  in  1 each  requester 1 (DMA/debug) request, fetch flag, burst lock.
REQ-008 m1_addr/m1_wdata  in  32 each; m1_wstrb  in  4; m1_ready  out  1; m1_rdata  out  32.
REQ-009 s_valid/s_instr  out  1 each  downstream request to picorv32_axi_adapter native port.
REQ-010 s_addr/s_wdata  out  32 each; s_wstrb  out  4; s_ready  in  1; s_rdata  in  32.
REQ-011 grant_id  out  1  owner of current/last transaction; busy  out  1  transaction outstanding.

Function
REQ-012 All requesters and the downstream port SHALL use picorv32 native protocol: valid held with stable fields until ready; one-cycle ready pulse completes the transfer.
REQ-013 FSM states IDLE and BUSY; IDLE->BUSY on any m*_valid; BUSY->IDLE on s_ready.
REQ-014 In IDLE with requests pending, winner SHALL be chosen per REQ-015..017 and its addr/wdata/wstrb/instr latched into internal registers on that edge.
REQ-015 ROUND_ROBIN=1: on simultaneous requests, the requester not granted last wins; rr pointer SHALL update only on completion.
REQ-016 ROUND_ROBIN=0: m0 SHALL win every simultaneous request.
REQ-017 If m1 owned the last transaction, m1_lock=1, m1_valid=1 and lock count < LOCK_MAX, m1 SHALL win regardless of m0; lock count increments per locked grant and clears when m1 loses or m1_lock=0.
REQ-018 s_valid SHALL equal busy; s_addr/s_wdata/s_wstrb/s_instr SHALL come only from latched registers, never combinationally from requesters.
REQ-019 Arbitration latency: first request cycle is IDLE, s_valid high on the next cycle; minimum transaction = 2 cycles plus downstream latency.
REQ-020 mN_ready SHALL equal s_ready AND busy AND (grant_id==N), combinationally; other ready held 0.
REQ-021 m0_rdata and m1_rdata SHALL both be driven with s_rdata unconditionally.
REQ-022 Granted requester dropping valid during BUSY SHALL NOT abort the downstream transfer; it completes and the ready pulse is still issued.
REQ-023 s_ready in IDLE SHALL be ignored.
REQ-024 Back-to-back: completion cycle returns to IDLE; a held request is re-arbitrated there, so a 1-cycle idle gap occurs between transfers.

Reset
REQ-025 On resetn low: state IDLE, busy=0, s_valid=0, m0_ready=m1_ready=0, grant_id=0, rr pointer favours m0, lock count 0, latched fields 0.
REQ-026 Reset mid-BUSY SHALL drop s_valid asynchronously; the downstream adapter shares resetn.

Structure
REQ-027 State encoding, requester-index constants and the 4-field request record width (69 bits) SHALL reside in shared package picodevice_pkg.
REQ-028 One sub-module, picodevice_rr_pick (2-way round-robin/priority/lock select, combinational + pointer/lock-count registers), is natural; the arbiter is instantiated between picorv32 and picorv32_axi_adapter.

Verification
REQ-029 m0 read 0x100 alone, s_ready after 3 cycles with s_rdata 0x12345678 -> s_valid 1 cycle after m0_valid, m0_ready one pulse, m0_rdata 0x12345678, m1_ready 0.
REQ-030 m0 and m1 valid same cycle, ROUND_ROBIN=1, from reset -> m0 served first, m1 second, 1 idle gap, grant_id 0 then 1.
REQ-031 ROUND_ROBIN=0, both held continuously for 4 transfers -> all four to m0, m1 starved.
REQ-032 m1_lock=1, LOCK_MAX=3, both always valid, m1 granted first -> three m1 grants, then m0, lock count cleared.
REQ-033 m1 write 0xA5A5A5A5 wstrb 0xF to 0x200, m1_addr changed to 0x300 mid-BUSY -> s_addr stays 0x200 until s_ready.
REQ-034 resetn low while BUSY -> s_valid, busy, both ready 0 same cycle; after release first request granted to m0.
